// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: scheduler state encoding, ADC code width and channel-id width helper.
package cnn1d_pkg;

    localparam int ADC_WIDTH = 12;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

    function automatic int ch_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_tag_fifo.sv
// chan_tag_fifo: synchronous tag FIFO with first-word-fall-through head.
module chan_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/adc_chan_sched.sv
// adc_chan_sched: round-robin ADC channel scheduler with result tagging.
// Optional ADC_CHAN_SCHED_STATS_EN adds per-channel saturating grant counters.
module adc_chan_sched
    import cnn1d_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_DEPTH   = 16,
    localparam int CH_ID_WIDTH = ch_id_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_in,
    output logic                        busy_out,
    output logic                        err_out,
    input  logic [NUM_CH-1:0]           ch_valid_in,
    output logic [NUM_CH-1:0]           ch_ready_out,
    input  logic [NUM_CH*ADC_WIDTH-1:0] ch_data_in,
    output logic                        conv_valid_out,
    input  logic                        conv_ready_in,
    output logic [ADC_WIDTH-1:0]        conv_data_out,
    input  logic                        res_valid_in,
    output logic                        res_ready_out,
    input  logic [DATA_WIDTH-1:0]       res_data_in,
`ifdef ADC_CHAN_SCHED_STATS_EN
    output logic [NUM_CH*16-1:0]        stat_count_out,
`endif
    output logic                        voltage_valid_out,
    input  logic                        voltage_ready_in,
    output logic [DATA_WIDTH-1:0]       voltage_data_out,
    output logic [CH_ID_WIDTH-1:0]      voltage_chan_out
);

    sched_state_t           state_q;
    logic [CH_ID_WIDTH-1:0] ptr_q, gnt_id, cand;
    logic                   conv_valid_q, err_q;
    logic [ADC_WIDTH-1:0]   conv_data_q;
    logic                   gnt_ok, gnt_vld, fifo_full, fifo_empty, res_pop, in_flight;

    always_comb begin
        gnt_ok  = (state_q == RUN) && enable_in && !fifo_full && (!conv_valid_q || conv_ready_in);
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_ID_WIDTH'((int'(ptr_q) + k) % NUM_CH);
            if (gnt_ok && !gnt_vld && ch_valid_in[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    assign ch_ready_out      = gnt_vld ? (NUM_CH'(1) << gnt_id) : '0;
    assign res_pop           = res_valid_in & voltage_ready_in & ~fifo_empty;
    assign in_flight         = ~fifo_empty | conv_valid_q;
    assign busy_out          = state_q != IDLE;
    assign err_out           = err_q;
    assign conv_valid_out    = conv_valid_q;
    assign conv_data_out     = conv_data_q;
    assign voltage_valid_out = res_valid_in & ~fifo_empty;
    assign voltage_data_out  = res_data_in;
    assign res_ready_out     = voltage_ready_in | fifo_empty;

    chan_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(CH_ID_WIDTH)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (gnt_vld),
        .data_i  (gnt_id),
        .pop_i   (res_pop),
        .head_o  (voltage_chan_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Grants are suppressed on the cycle enable drops so no tag is pushed while leaving RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (enable_in) state_q <= RUN;
                RUN:     if (!enable_in) state_q <= in_flight ? DRAIN : IDLE;
                default: if (!in_flight) state_q <= IDLE;
            endcase
            if (gnt_vld) begin
                ptr_q        <= (int'(gnt_id) == NUM_CH - 1) ? '0 : gnt_id + 1'b1;
                conv_valid_q <= 1'b1;
                conv_data_q  <= ch_data_in[int'(gnt_id)*ADC_WIDTH +: ADC_WIDTH];
            end else if (conv_ready_in) begin
                conv_valid_q <= 1'b0;
            end
            if (res_valid_in && fifo_empty) err_q <= 1'b1;
        end
    end

`ifdef ADC_CHAN_SCHED_STATS_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
        logic [15:0] stat_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) stat_q <= '0;
            else if (ch_ready_out[c] && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
        end
        assign stat_count_out[c*16 +: 16] = stat_q;
    end
`endif

endmodule

// File: tb/tb_adc_chan_sched.sv
// tb_adc_chan_sched: randomized scoreboard bench against a queue-based scheduler model.
module tb_adc_chan_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TD = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable_in = 1'b0;
    logic          busy_out, err_out;
    logic [N-1:0]  ch_valid_in = '0;
    logic [N-1:0]  ch_ready_out;
    logic [N*AW-1:0] ch_data_in = '0;
    logic          conv_valid_out;
    logic          conv_ready_in = 1'b0;
    logic [AW-1:0] conv_data_out;
    logic          res_valid_in = 1'b0;
    logic          res_ready_out;
    logic [DW-1:0] res_data_in = '0;
    logic          voltage_valid_out;
    logic          voltage_ready_in = 1'b0;
    logic [DW-1:0] voltage_data_out;
    logic [1:0]    voltage_chan_out;

    always #5 clk = ~clk;

    adc_chan_sched #(.NUM_CH(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable_in         (enable_in),
        .busy_out          (busy_out),
        .err_out           (err_out),
        .ch_valid_in       (ch_valid_in),
        .ch_ready_out      (ch_ready_out),
        .ch_data_in        (ch_data_in),
        .conv_valid_out    (conv_valid_out),
        .conv_ready_in     (conv_ready_in),
        .conv_data_out     (conv_data_out),
        .res_valid_in      (res_valid_in),
        .res_ready_out     (res_ready_out),
        .res_data_in       (res_data_in),
        .voltage_valid_out (voltage_valid_out),
        .voltage_ready_in  (voltage_ready_in),
        .voltage_data_out  (voltage_data_out),
        .voltage_chan_out  (voltage_chan_out)
    );

    int checks = 0;
    int failures = 0;

    // Model: 0=IDLE 1=RUN 2=DRAIN; tags in flight; conversion slot occupied; sticky error.
    int            m_state = 0;
    int            m_ptr = 0;
    int            m_tags[$];
    bit            m_conv = 0;
    bit            m_err = 0;
    logic [AW-1:0] exp_conv[$];
    int            exp_ch[$];
    logic [DW-1:0] exp_d[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit en, input logic [N-1:0] vmask, input int cr_pct,
                        input int rv_pct, input int vr_pct);
        int g;
        bit inflight, conv_free;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        enable_in        = en;
        ch_valid_in      = vmask & N'($urandom);
        for (int i = 0; i < N; i++) ch_data_in[i*AW +: AW] = AW'($urandom);
        conv_ready_in    = $urandom_range(99) < cr_pct;
        res_valid_in     = $urandom_range(99) < rv_pct;
        res_data_in      = $urandom;
        voltage_ready_in = $urandom_range(99) < vr_pct;
        #1;
        g = -1;
        conv_free = !m_conv || conv_ready_in;
        if (m_state == 1 && en && m_tags.size() < TD && conv_free)
            for (int k = 0; k < N; k++)
                if (g < 0 && ch_valid_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("ch_ready", 64'(ch_ready_out), 64'(exp_rdy));
        chk("busy", 64'(busy_out), 64'(m_state != 0));
        chk("err", 64'(err_out), 64'(m_err));
        chk("res_ready", 64'(res_ready_out), 64'(voltage_ready_in || m_tags.size() == 0));
        chk("volt_valid", 64'(voltage_valid_out), 64'(res_valid_in && m_tags.size() > 0));
        inflight = m_tags.size() > 0 || m_conv;
        if (res_valid_in && m_tags.size() == 0) m_err = 1;
        if (res_valid_in && voltage_ready_in && m_tags.size() > 0) begin
            exp_ch.push_back(m_tags.pop_front());
            exp_d.push_back(res_data_in);
        end
        if (g >= 0) begin
            m_tags.push_back(g);
            exp_conv.push_back(ch_data_in[g*AW +: AW]);
            m_ptr = (g + 1) % N;
            m_conv = 1;
        end else if (conv_ready_in) begin
            m_conv = 0;
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = inflight ? 2 : 0;
            default: if (!inflight) m_state = 0;
        endcase
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_conv_valid", 64'(conv_valid_out), 0);
        chk("rst_conv_data", 64'(conv_data_out), 0);
        chk("rst_err", 64'(err_out), 0);
        chk("rst_busy", 64'(busy_out), 0);
        chk("rst_ch_ready", 64'(ch_ready_out), 0);
        enable_in = 0; ch_valid_in = '0; conv_ready_in = 0; res_valid_in = 0; voltage_ready_in = 0;
        m_state = 0; m_ptr = 0; m_conv = 0; m_err = 0;
        m_tags.delete(); exp_conv.delete(); exp_ch.delete(); exp_d.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        #2;
        if (conv_valid_out && conv_ready_in) begin
            if (exp_conv.size() == 0) begin
                checks++; failures++;
                $display("FAIL conv_unexpected got=%0h want=none", conv_data_out);
            end else chk("conv_data", 64'(conv_data_out), 64'(exp_conv.pop_front()));
        end
        if (voltage_valid_out && voltage_ready_in) begin
            if (exp_ch.size() == 0) begin
                checks++; failures++;
                $display("FAIL volt_unexpected got=%0h want=none", voltage_data_out);
            end else begin
                chk("volt_chan", 64'(voltage_chan_out), 64'(exp_ch.pop_front()));
                chk("volt_data", 64'(voltage_data_out), 64'(exp_d.pop_front()));
            end
        end
    end

    initial begin
        #2;
        chk("init_conv_valid", 64'(conv_valid_out), 0);
        chk("init_busy", 64'(busy_out), 0);
        chk("init_err", 64'(err_out), 0);
        chk("init_ch_ready", 64'(ch_ready_out), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(0, '0, 100, 100, 100);
        repeat (30) step(1, 4'hF, 100, 0, 100);
        repeat (20) step(1, 4'h0, 100, 100, 100);
        repeat (20) step(1, 4'hF, 0, 0, 100);
        repeat (20) step(1, 4'b0100, 100, 60, 100);
        repeat (8) step(1, 4'hF, 100, 0, 100);
        repeat (30) step(0, 4'hF, 100, 30, 70);
        repeat (300) step($urandom_range(9) != 0, N'($urandom), $urandom_range(30, 100),
                          $urandom_range(0, 80), $urandom_range(30, 100));
        repeat (10) step(1, 4'hF, 100, 0, 100);
        mid_reset();
        repeat (200) step($urandom_range(9) != 0, N'($urandom), $urandom_range(30, 100),
                          $urandom_range(0, 80), $urandom_range(30, 100));
        repeat (60) step(0, 4'h0, 100, 100, 100);
        chk("final_busy", 64'(busy_out), 0);
        chk("final_conv_pending", 64'(exp_conv.size()), 0);
        chk("final_volt_pending", 64'(exp_ch.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
